// File: rtl/sha_msg_padder.sv
// sha_msg_padder
//
// SHA-2 message padder. Collects raw message bytes from a 64-bit AXI-Stream
// slave into a 64-byte chunk buffer and applies FIPS 180-4 padding: a 0x80
// byte, zero fill, and the big-endian message bit length. Padded chunks leave
// on a 512-bit AXI-Stream master. For SHA-224/256 one chunk is one block.
// For SHA-384/512 one block is two chunks, left half first, then right half.
//
// Ports
//   axis_aclk, axis_reset    : clock; asynchronous active-high reset
//   s_axis_tdata/tkeep/tuser : message beat; byte k = tdata[8k+7:8k];
//                              tuser[33:32] = sha_type, taken from the first beat
//   s_axis_tvalid/tready     : input handshake
//   s_axis_tlast             : last beat of the message
//   m_axis_tdata/tuser       : padded chunk and the tuser latched for the message
//   m_axis_tvalid/tready     : output handshake
//   m_axis_tlast             : last chunk of the message
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// tvalid and tready are both high. Once asserted, tvalid stays high until that
// transfer happens. The payload is held stable while it waits. The slave side
// accepts beats only in FILL. The master side presents data only in SEND, so
// input and output never overlap.
//
// The FSM state is held in state_q, with encodings ST_*.

module sha_msg_padder #(
  parameter int C_S_AXIS_DATA_WIDTH  = 64,
  parameter int C_M_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              axis_aclk,
  input  logic                              axis_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [511:0] buf_q, buf_d;
  logic [6:0]   ptr_q, ptr_d;
  logic [60:0]  len_q, len_d;
  logic         half_q, half_d;
  logic         pad_q, pad_d;
  logic         first_q, first_d;
  logic         final_q, final_d;
  logic         tail_q, tail_d;
  logic [127:0] tuser_q, tuser_d;

  logic [3:0]   n_keep;
  logic [6:0]   beat_ptr;
  logic [60:0]  beat_len;
  logic         cur_wide;
  logic [5:0]   widx;
  logic [6:0]   tail_used;

  // Returns 1 if the length field fits in the current chunk.
  // In narrow mode it fits after at most 56 used bytes. In wide mode it fits
  // only in the right half, after at most 48 used bytes; bytes 48..55 then
  // hold the upper 64 bits of the 128-bit length, which are always zero.
  function automatic logic len_fits(input logic wide, input logic h, input logic [6:0] used);
    if (wide) return h && (used <= 7'd48);
    return used <= 7'd56;
  endfunction

  // Writes {len, 3'b000} big-endian into bytes 56..63. Byte 56 gets bits 63:56.
  function automatic logic [511:0] put_len(input logic [511:0] b, input logic [60:0] l);
    logic [511:0] r;
    logic [63:0]  lb;
    r  = b;
    lb = {l, 3'b000};
    for (int i = 0; i < 8; i++) r[448 + 8*i +: 8] = lb[63 - 8*i -: 8];
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    half_d    = half_q;
    pad_d     = pad_q;
    first_d   = first_q;
    final_d   = final_q;
    tail_d    = tail_q;
    tuser_d   = tuser_q;
    widx      = '0;
    tail_used = '0;

    n_keep = '0;
    for (int k = 0; k < 8; k++) n_keep = n_keep + {3'b000, s_axis_tkeep[k]};
    beat_ptr = ptr_q + {3'b000, n_keep};
    beat_len = (first_q ? 61'd0 : len_q) + {57'd0, n_keep};
    // The first beat of a message supplies its own sha_type.
    cur_wide = first_q ? s_axis_tuser[33] : tuser_q[33];

    case (state_q)
      ST_IDLE: state_d = ST_FILL;

      ST_FILL: begin
        if (s_axis_tvalid) begin
          if (first_q) begin
            tuser_d = s_axis_tuser;
            first_d = 1'b0;
          end
          // tkeep is contiguous from bit 0, so kept byte k lands at ptr+k.
          for (int k = 0; k < 8; k++) begin
            if (s_axis_tkeep[k]) begin
              widx = ptr_q[5:0] + 6'(k);
              buf_d[{widx, 3'b000} +: 8] = s_axis_tdata[8*k +: 8];
            end
          end
          ptr_d = beat_ptr;
          len_d = beat_len;
          if (!s_axis_tlast) begin
            if (beat_ptr == 7'd64) state_d = ST_SEND;
          end else begin
            if (beat_ptr < 7'd64) begin
              // The buffer is already zero beyond ptr, so only the 0x80 byte is written.
              buf_d[{beat_ptr[5:0], 3'b000} +: 8] = 8'h80;
              if (len_fits(cur_wide, half_q, beat_ptr + 7'd1)) begin
                buf_d   = put_len(buf_d, beat_len);
                final_d = 1'b1;
              end else begin
                tail_d = 1'b1;
              end
            end else begin
              pad_d  = 1'b1;
              tail_d = 1'b1;
            end
            state_d = ST_SEND;
          end
        end
      end

      ST_SEND: begin
        if (m_axis_tready) begin
          buf_d = '0;
          ptr_d = '0;
          if (final_q) begin
            first_d = 1'b1;
            final_d = 1'b0;
            half_d  = 1'b0;
            state_d = ST_FILL;
          end else begin
            if (tuser_q[33]) half_d = ~half_q;
            state_d = tail_q ? ST_TAIL : ST_FILL;
          end
        end
      end

      ST_TAIL: begin
        // Padding-only chunk. It starts with 0x80 if the message ended exactly
        // on a chunk boundary.
        if (pad_q) begin
          buf_d[7:0] = 8'h80;
          tail_used  = 7'd1;
          pad_d      = 1'b0;
        end
        if (len_fits(tuser_q[33], half_q, tail_used)) begin
          buf_d   = put_len(buf_d, len_q);
          final_d = 1'b1;
          tail_d  = 1'b0;
        end
        state_d = ST_SEND;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      half_q  <= 1'b0;
      pad_q   <= 1'b0;
      first_q <= 1'b1;
      final_q <= 1'b0;
      tail_q  <= 1'b0;
      tuser_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      half_q  <= half_d;
      pad_q   <= pad_d;
      first_q <= first_d;
      final_q <= final_d;
      tail_q  <= tail_d;
      tuser_q <= tuser_d;
    end
  end

  assign s_axis_tready = (state_q == ST_FILL);
  assign m_axis_tvalid = (state_q == ST_SEND);
  assign m_axis_tlast  = (state_q == ST_SEND) && final_q;
  assign m_axis_tdata  = buf_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Testbench for sha_msg_padder.
// Expected chunks come from two sources. Hand-written constants cover the
// short-message cases. For the other cases, a byte-level FIPS 180-4 padding
// model builds the padded message and slices it into 64-byte chunks.

module tb_sha_msg_padder;

  logic         axis_aclk = 1'b0;
  logic         axis_reset = 1'b1;
  logic [63:0]  s_axis_tdata = '0;
  logic [7:0]   s_axis_tkeep = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [511:0] m_axis_tdata;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;

  sha_msg_padder dut (
    .axis_aclk     (axis_aclk),
    .axis_reset    (axis_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  // ---------------- clock / reset ----------------
  always #5 axis_aclk = ~axis_aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- shared state ----------------
  typedef struct {
    logic [1:0] sha_type;
    int         msg_len;
    int         exp_chunks;
  } vec_t;

  vec_t         vecs[12];
  logic [7:0]   msg_q[$];
  logic [511:0] exp_q[$];
  logic         exp_last_q[$];
  logic [127:0] exp_user_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int           chunk_cnt = 0;
  logic         bp_hold = 1'b0;
  logic         rand_bp = 1'b0;

  logic [511:0] mon_data;
  logic         mon_last;
  logic [127:0] mon_user;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Downstream ready. It changes only just after a rising edge.
  always @(posedge axis_aclk) begin
    #1;
    if (bp_hold) m_axis_tready = 1'b0;
    else if (rand_bp) m_axis_tready = ($urandom_range(0, 3) != 0);
    else m_axis_tready = 1'b1;
  end

  // ---------------- scoreboard ----------------
  always @(negedge axis_aclk) begin
    if (!axis_reset && m_axis_tvalid && m_axis_tready) begin
      chunk_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_chunk actual=%h required=none", m_axis_tdata);
      end else begin
        mon_data = exp_q.pop_front();
        mon_last = exp_last_q.pop_front();
        mon_user = exp_user_q.pop_front();
        check("chunk_data", m_axis_tdata, mon_data);
        check("chunk_tlast", 512'(m_axis_tlast), 512'(mon_last));
        check("chunk_tuser", 512'(m_axis_tuser), 512'(mon_user));
      end
    end
  end

  // Reference model: FIPS 180-4 padding on the byte queue, then 64-byte slicing.
  task automatic model_push(input logic [1:0] t, input logic [127:0] user);
    logic [7:0]   pm[$];
    logic [127:0] bits;
    logic [511:0] ch;
    int blk, lenb, nch;
    pm = msg_q;
    pm.push_back(8'h80);
    blk  = t[1] ? 128 : 64;
    lenb = t[1] ? 16 : 8;
    while ((pm.size() % blk) != (blk - lenb)) pm.push_back(8'h00);
    bits = 128'(msg_q.size()) * 128'd8;
    for (int i = lenb - 1; i >= 0; i--) pm.push_back(bits[8*i +: 8]);
    nch = pm.size() / 64;
    for (int c = 0; c < nch; c++) begin
      ch = '0;
      for (int k = 0; k < 64; k++) ch[8*k +: 8] = pm[64*c + k];
      exp_q.push_back(ch);
      exp_last_q.push_back(c == nch - 1);
      exp_user_q.push_back(user);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [127:0] u);
    logic acc;
    int   cyc;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    acc = 1'b0;
    cyc = 0;
    while (!acc) begin
      @(negedge axis_aclk);
      acc = s_axis_tready;
      @(posedge axis_aclk);
      #1;
      cyc++;
      if (!acc && cyc > 300) begin
        n_checks++;
        $display("FAIL beat_accept_timeout actual=no_tready required=tready within 300 cycles");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Drives msg_q. Beats after the first carry random tuser, which must be ignored.
  task automatic drive_msg(input logic [127:0] user, input logic gaps);
    int len, beats, idx;
    logic [63:0]  d;
    logic [7:0]   k;
    logic [127:0] u;
    len   = msg_q.size();
    beats = (len == 0) ? 1 : (len + 7) / 8;
    for (int b = 0; b < beats; b++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 8; j++) begin
        idx = 8*b + j;
        if (idx < len) begin
          k[j] = 1'b1;
          d[8*j +: 8] = msg_q[idx];
        end
      end
      u = (b == 0) ? user : {$urandom, $urandom, $urandom, $urandom};
      drive_beat(d, k, (b == beats - 1), u);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge axis_aclk); #1; end
    end
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge axis_aclk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout actual=%0d chunks pending required=0", exp_q.size());
    end
    repeat (3) @(negedge axis_aclk);
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic rand_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  function automatic logic [127:0] mk_user(input logic [1:0] t);
    logic [127:0] u;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[33:32] = t;
    return u;
  endfunction

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [511:0] abc256, abc512_l, abc512_r;
    logic [127:0] user;
    int           rlen;
    logic [1:0]   rt;

    vecs[0]  = '{2'd1, 3,   1};
    vecs[1]  = '{2'd1, 55,  1};
    vecs[2]  = '{2'd1, 56,  2};
    vecs[3]  = '{2'd0, 64,  2};
    vecs[4]  = '{2'd3, 3,   2};
    vecs[5]  = '{2'd2, 112, 4};
    vecs[6]  = '{2'd2, 111, 2};
    vecs[7]  = '{2'd3, 64,  2};
    vecs[8]  = '{2'd3, 128, 4};
    vecs[9]  = '{2'd0, 0,   1};
    vecs[10] = '{2'd1, 119, 2};
    vecs[11] = '{2'd1, 120, 3};

    abc256 = '0;
    abc256[23:0]    = 24'h636261;
    abc256[31:24]   = 8'h80;
    abc256[511:504] = 8'h18;
    abc512_l = '0;
    abc512_l[31:0]  = 32'h80636261;
    abc512_r = '0;
    abc512_r[511:504] = 8'h18;

    // Reset values.
    repeat (3) @(negedge axis_aclk);
    check("rst_s_tready", 512'(s_axis_tready), 512'(0));
    check("rst_m_tvalid", 512'(m_axis_tvalid), 512'(0));
    check("rst_m_tlast", 512'(m_axis_tlast), 512'(0));
    check("rst_m_tdata", m_axis_tdata, 512'(0));
    check("rst_m_tuser", 512'(m_axis_tuser), 512'(0));
    axis_reset = 1'b0;
    #1;
    check("idle_tready", 512'(s_axis_tready), 512'(0));
    @(negedge axis_aclk);
    check("fill_tready_after_first_edge", 512'(s_axis_tready), 512'(1));
    @(posedge axis_aclk);
    #1;

    // "abc" with SHA-256.
    user = mk_user(2'd1);
    load_abc();
    exp_q.push_back(abc256); exp_last_q.push_back(1'b1); exp_user_q.push_back(user);
    chunk_cnt = 0;
    drive_msg(user, 1'b0);
    wait_drain();
    check("abc256_chunks", 512'(chunk_cnt), 512'(1));

    // "abc" with SHA-512: left half, then right half.
    user = mk_user(2'd3);
    load_abc();
    exp_q.push_back(abc512_l); exp_last_q.push_back(1'b0); exp_user_q.push_back(user);
    exp_q.push_back(abc512_r); exp_last_q.push_back(1'b1); exp_user_q.push_back(user);
    chunk_cnt = 0;
    drive_msg(user, 1'b0);
    wait_drain();
    check("abc512_chunks", 512'(chunk_cnt), 512'(2));

    // Table of lengths around padding boundaries, with random backpressure.
    rand_bp = 1'b1;
    for (int v = 0; v < 12; v++) begin
      user = mk_user(vecs[v].sha_type);
      rand_msg(vecs[v].msg_len);
      model_push(vecs[v].sha_type, user);
      chunk_cnt = 0;
      drive_msg(user, 1'b1);
      wait_drain();
      check($sformatf("vec%0d_chunks", v), 512'(chunk_cnt), 512'(vecs[v].exp_chunks));
    end
    rand_bp = 1'b0;

    // Backpressure: output held for 5 cycles; tvalid rises the cycle after tlast.
    bp_hold = 1'b1;
    user = mk_user(2'd1);
    load_abc();
    exp_q.push_back(abc256); exp_last_q.push_back(1'b1); exp_user_q.push_back(user);
    drive_msg(user, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge axis_aclk);
      check("bp_tvalid", 512'(m_axis_tvalid), 512'(1));
      check("bp_tdata", m_axis_tdata, abc256);
      check("bp_tuser", 512'(m_axis_tuser), 512'(user));
      check("bp_s_tready", 512'(s_axis_tready), 512'(0));
    end
    @(posedge axis_aclk);
    #1;
    bp_hold = 1'b0;
    wait_drain();

    // Reset while a full chunk is waiting for tready.
    bp_hold = 1'b1;
    user = mk_user(2'd1);
    for (int b = 0; b < 8; b++) drive_beat({$urandom, $urandom}, 8'hFF, 1'b0, user);
    @(negedge axis_aclk);
    check("full_chunk_tvalid", 512'(m_axis_tvalid), 512'(1));
    axis_reset = 1'b1;
    #1;
    check("async_rst_tvalid", 512'(m_axis_tvalid), 512'(0));
    check("async_rst_tready", 512'(s_axis_tready), 512'(0));
    check("async_rst_tdata", m_axis_tdata, 512'(0));
    bp_hold = 1'b0;
    repeat (2) @(negedge axis_aclk);
    axis_reset = 1'b0;
    repeat (2) @(posedge axis_aclk);
    #1;
    user = mk_user(2'd1);
    load_abc();
    exp_q.push_back(abc256); exp_last_q.push_back(1'b1); exp_user_q.push_back(user);
    chunk_cnt = 0;
    drive_msg(user, 1'b0);
    wait_drain();
    check("abc_after_reset_chunks", 512'(chunk_cnt), 512'(1));

    // Random messages checked against the padding model.
    rand_bp = 1'b1;
    for (int r = 0; r < 40; r++) begin
      rt   = 2'($urandom_range(0, 3));
      rlen = $urandom_range(0, 200);
      user = mk_user(rt);
      rand_msg(rlen);
      model_push(rt, user);
      drive_msg(user, ($urandom_range(0, 1) == 1));
      wait_drain();
    end
    rand_bp = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
